lvds_rx_deframer: RTL and testbench

LVDS_RX_DEFRAMER -- requirements
Module: lvds_rx_deframer

---
 rtl/lvds_link_pkg.sv | 17 +
 rtl/lvds_rx_deframer_if.sv | 9 +
 rtl/lvds_rx_fifo2.sv | 50 +++++
 rtl/lvds_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_lvds_rx_deframer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link framer/deframer pair: link FSM states,
// default training/header bytes and the position of the word valid bit.
package lvds_link_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HUNT,
    SETTLE,
    WAIT_HDR,
    DATA
  } link_state_e;

  localparam logic [7:0] TRAIN_PAT_DEF = 8'h35;
  localparam logic [7:0] HDR_PAT_DEF   = 8'h77;
  localparam int         VALID_BIT     = 31;

endpackage

// File: rtl/lvds_rx_deframer_if.sv
// Word dequeue handshake between the deframer (master) and its consumer (slave).
interface lvds_rx_deframer_if;
    logic [31:0] deq_rx;
    logic        EN_deq_rx;
    logic        RDY_deq_rx;

    modport master (output deq_rx, output EN_deq_rx, input RDY_deq_rx);
    modport slave  (input deq_rx, input EN_deq_rx, output RDY_deq_rx);
endinterface

// File: rtl/lvds_rx_fifo2.sv
// Two-entry FIFO for received words; push while full is accepted only when a pop
// frees a slot in the same cycle. The head reads as zero when empty.
module lvds_rx_fifo2 (
    input  logic        rx_outclock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);
    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? 32'h0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge rx_outclock) begin
        if (!reset_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge rx_outclock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/lvds_rx_deframer.sv
// LVDS receive deframer: bitslip word alignment on a training byte, header
// detection, 4-byte word assembly and a 2-deep output buffer with drop counting.
module lvds_rx_deframer
    import lvds_link_pkg::*;
#(
    parameter logic [7:0] TRAIN_PAT    = TRAIN_PAT_DEF,
    parameter logic [7:0] HDR_PAT      = HDR_PAT_DEF,
    parameter int         SETTLE_CYC   = 3,
    parameter int         LOCK_MATCHES = 4
) (
    input  logic                      rx_outclock,
    input  logic                      reset_n,
    input  logic                      rx_locked,
    input  logic [7:0]                rx_out,
    output logic                      rx_data_align,
    output logic                      rx_align_done,
    output logic [7:0]                drop_cnt,
    lvds_rx_deframer_if.master        deq
);
    link_state_e state_q, state_n;
    logic [7:0]  match_q, match_n;
    logic [7:0]  settle_q, settle_n;
    logic [1:0]  idx_q, idx_n;
    logic [23:0] shreg_q, shreg_n;
    logic        pend_q, pend_n;
    logic [31:0] pend_word_q, pend_word_n;
    logic        align_n;
    logic        done_n;
    logic        lock_lost;
    logic [31:0] word;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign lock_lost = (state_q != WAIT_LOCK) && !rx_locked;
    assign word      = {shreg_q, rx_out};

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state_q;
        match_n     = match_q;
        settle_n    = settle_q;
        idx_n       = idx_q;
        shreg_n     = shreg_q;
        pend_n      = 1'b0;
        pend_word_n = pend_word_q;
        align_n     = 1'b0;
        case (state_q)
            WAIT_LOCK: if (rx_locked) state_n = HUNT;
            HUNT: begin
                if (rx_out == TRAIN_PAT) begin
                    match_n = match_q + 8'd1;
                    if (match_n == 8'(LOCK_MATCHES)) state_n = WAIT_HDR;
                end else begin
                    match_n  = 8'd0;
                    settle_n = 8'd0;
                    align_n  = 1'b1;
                    state_n  = SETTLE;
                end
            end
            // The bitslip pulse occupies the first SETTLE cycle; SETTLE_CYC quiet cycles follow.
            SETTLE: begin
                if (settle_q == 8'(SETTLE_CYC)) state_n = HUNT;
                else                            settle_n = settle_q + 8'd1;
            end
            WAIT_HDR: begin
                if (rx_out == HDR_PAT) begin
                    state_n = DATA;
                    idx_n   = 2'd0;
                end
            end
            DATA: begin
                idx_n   = idx_q + 2'd1;
                shreg_n = {shreg_q[15:0], rx_out};
                if (idx_q == 2'd3 && word[VALID_BIT]) begin
                    pend_n      = 1'b1;
                    pend_word_n = word;
                end
            end
            default: state_n = WAIT_LOCK;
        endcase
        if (lock_lost) begin
            state_n  = WAIT_LOCK;
            match_n  = 8'd0;
            settle_n = 8'd0;
            idx_n    = 2'd0;
            pend_n   = 1'b0;
            align_n  = 1'b0;
        end
        done_n = (state_n == WAIT_HDR) || (state_n == DATA);
    end

    always_ff @(posedge rx_outclock) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            match_q       <= 8'd0;
            settle_q      <= 8'd0;
            idx_q         <= 2'd0;
            shreg_q       <= 24'h0;
            pend_q        <= 1'b0;
            pend_word_q   <= 32'h0;
            rx_data_align <= 1'b0;
            rx_align_done <= 1'b0;
        end else begin
            state_q       <= state_n;
            match_q       <= match_n;
            settle_q      <= settle_n;
            idx_q         <= idx_n;
            shreg_q       <= shreg_n;
            pend_q        <= pend_n;
            pend_word_q   <= pend_word_n;
            rx_data_align <= align_n;
            rx_align_done <= done_n;
        end
    end

    // The completed word waits one cycle in pend_* before entering the buffer.
    assign fifo_push     = pend_q && !lock_lost;
    assign fifo_pop      = !fifo_empty && deq.RDY_deq_rx;
    assign deq.EN_deq_rx = fifo_pop;

    lvds_rx_fifo2 u_fifo (
        .rx_outclock (rx_outclock),
        .reset_n     (reset_n),
        .flush       (lock_lost),
        .push        (fifo_push),
        .push_data   (pend_word_q),
        .pop         (fifo_pop),
        .head        (deq.deq_rx),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_ff @(posedge rx_outclock) begin
        if (!reset_n)
            drop_cnt <= 8'd0;
        else if (fifo_push && fifo_full && !fifo_pop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer: a table of per-cycle vectors for the main
// data path plus hand-written sequences for saturation, lock loss, reset and bitslip.
module tb_lvds_rx_deframer;
    logic       rx_outclock = 1'b0;
    logic       reset_n;
    logic       rx_locked;
    logic [7:0] rx_out;
    logic       rx_data_align;
    logic       rx_align_done;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    lvds_rx_deframer_if deq_if ();

    lvds_rx_deframer dut (
        .rx_outclock   (rx_outclock),
        .reset_n       (reset_n),
        .rx_locked     (rx_locked),
        .rx_out        (rx_out),
        .rx_data_align (rx_data_align),
        .rx_align_done (rx_align_done),
        .drop_cnt      (drop_cnt),
        .deq           (deq_if)
    );

    always #5 rx_outclock = ~rx_outclock;

    typedef struct {
        logic        locked;
        logic [7:0]  b;
        logic        rdy;
        logic        done;
        logic        en;
        logic [31:0] deq;
        logic [7:0]  drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic l, input logic [7:0] b, input logic r,
                       input logic d, input logic e, input logic [31:0] q, input logic [7:0] dr);
        vec_t v;
        v.locked = l; v.b = b; v.rdy = r; v.done = d; v.en = e; v.deq = q; v.drop = dr;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rx_outclock);
        #1;
    endtask

    task automatic drive(input logic l, input logic [7:0] b, input logic r);
        rx_locked = l;
        rx_out = b;
        deq_if.RDY_deq_rx = r;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    initial begin
        int en_seen;
        int pulses;
        int last_pulse;
        int offset;
        bit got_done;

        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        check("reset_done", rx_align_done, 0);
        check("reset_align", rx_data_align, 0);
        check("reset_en", deq_if.EN_deq_rx, 0);
        check("reset_deq", deq_if.deq_rx, 0);
        check("reset_drop", drop_cnt, 0);
        reset_n = 1'b1;

        // Lock, align (already aligned), header, DEADBEEF, idle word, overflow, push+pop at full.
        add(1, 8'h00, 1, 0, 0, 0, 0);
        add(1, 8'h35, 1, 0, 0, 0, 0);
        add(1, 8'h35, 1, 0, 0, 0, 0);
        add(1, 8'h35, 1, 0, 0, 0, 0);
        add(1, 8'h35, 1, 1, 0, 0, 0);
        add(1, 8'h00, 1, 1, 0, 0, 0);
        add(1, 8'h77, 1, 1, 0, 0, 0);
        add(1, 8'hDE, 1, 1, 0, 0, 0);
        add(1, 8'hAD, 1, 1, 0, 0, 0);
        add(1, 8'hBE, 1, 1, 0, 0, 0);
        add(1, 8'hEF, 1, 1, 0, 0, 0);
        add(1, 8'h12, 1, 1, 1, 32'hDEADBEEF, 0);
        add(1, 8'h34, 1, 1, 0, 0, 0);
        add(1, 8'h56, 1, 1, 0, 0, 0);
        add(1, 8'h78, 1, 1, 0, 0, 0);
        add(1, 8'h80, 0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, 0);
        add(1, 8'h80, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h02, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h80, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h03, 0, 1, 0, 32'h80000001, 0);
        add(1, 8'h80, 0, 1, 0, 32'h80000001, 1);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 1);
        add(1, 8'h00, 0, 1, 0, 32'h80000001, 1);
        add(1, 8'h04, 0, 1, 0, 32'h80000001, 1);
        add(1, 8'h00, 1, 1, 1, 32'h80000002, 1);
        add(1, 8'h00, 1, 1, 1, 32'h80000004, 1);
        add(1, 8'h00, 1, 1, 0, 0, 1);
        add(1, 8'h00, 1, 1, 0, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].locked, tbl[i].b, tbl[i].rdy);
            cyc();
            check($sformatf("vec%0d_done", i), rx_align_done, tbl[i].done);
            check($sformatf("vec%0d_en", i), deq_if.EN_deq_rx, tbl[i].en);
            check($sformatf("vec%0d_deq", i), deq_if.deq_rx, tbl[i].deq);
            check($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].drop);
        end

        // drop_cnt saturation: 260 valid words into a stalled buffer.
        for (int w = 0; w < 260; w++) begin
            drive(1, 8'h80, 0); cyc();
            drive(1, 8'h00, 0); cyc();
            drive(1, 8'h00, 0); cyc();
            drive(1, 8'(w), 0); cyc();
        end
        check("sat_drop", drop_cnt, 8'hFF);
        check("sat_head", deq_if.deq_rx, 32'h80000000);

        // Lock loss after two bytes of a word.
        drive(1, 8'h80, 0); cyc();
        drive(1, 8'h11, 0); cyc();
        drive(0, 8'h22, 1); cyc();
        check("loss_done", rx_align_done, 0);
        check("loss_en", deq_if.EN_deq_rx, 0);
        check("loss_deq", deq_if.deq_rx, 0);
        check("loss_drop_kept", drop_cnt, 8'hFF);
        en_seen = 0;
        drive(0, 8'h33, 1); cyc();
        en_seen += int'(deq_if.EN_deq_rx);
        drive(1, 8'h44, 1); cyc();
        en_seen += int'(deq_if.EN_deq_rx);
        check("relock_not_done", rx_align_done, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'h35, 1); cyc();
            en_seen += int'(deq_if.EN_deq_rx);
        end
        check("relock_done", rx_align_done, 1);
        drive(1, 8'h77, 1); cyc(); en_seen += int'(deq_if.EN_deq_rx);
        drive(1, 8'h80, 1); cyc(); en_seen += int'(deq_if.EN_deq_rx);
        drive(1, 8'hAB, 1); cyc(); en_seen += int'(deq_if.EN_deq_rx);
        drive(1, 8'hCD, 1); cyc(); en_seen += int'(deq_if.EN_deq_rx);
        drive(1, 8'hEF, 1); cyc(); en_seen += int'(deq_if.EN_deq_rx);
        check("relock_no_stale_en", en_seen, 0);
        drive(1, 8'h00, 1); cyc();
        check("relock_word_en", deq_if.EN_deq_rx, 1);
        check("relock_word", deq_if.deq_rx, 32'h80ABCDEF);

        // Reset mid-word, with inputs active, clears everything including drop_cnt.
        drive(1, 8'h80, 1); cyc();
        reset_n = 1'b0;
        drive(1, 8'h12, 1); cyc();
        check("rst2_done", rx_align_done, 0);
        check("rst2_en", deq_if.EN_deq_rx, 0);
        check("rst2_deq", deq_if.deq_rx, 0);
        check("rst2_drop", drop_cnt, 0);
        check("rst2_align", rx_data_align, 0);
        reset_n = 1'b1;

        // Bitslip: stream rotated by 3, one rotation step removed per rx_data_align pulse.
        offset = 3;
        pulses = 0;
        last_pulse = -100;
        got_done = 0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            drive(1, rotl(8'h35, offset), 0);
            cyc();
            if (rx_data_align) begin
                pulses++;
                check("slip_gap_ok", (c - last_pulse) >= 4, 1);
                last_pulse = c;
                if (offset > 0) offset--;
            end
            got_done = rx_align_done;
        end
        check("slip_pulses", pulses, 3);
        check("slip_done", got_done, 1);
        check("slip_final_offset", offset, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
